// File: rtl/xbar_bridge_req_arbiter.sv
// Round-robin request arbiter for the XBAR bridge slave port, with one-hot ID tagging and outstanding throttle.
// Optional master lock (data_lock_i) is enabled by defining BRIDGE_ARB_LOCK_EN.
module xbar_bridge_req_arbiter #(
  parameter int unsigned N_MASTER        = 20,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [N_MASTER-1:0]                      data_req_i,
  input  logic [N_MASTER*ADDR_WIDTH-1:0]           data_add_i,
  input  logic [N_MASTER-1:0]                      data_wen_i,
  input  logic [N_MASTER*DATA_WIDTH-1:0]           data_wdata_i,
  input  logic [N_MASTER*(DATA_WIDTH/8)-1:0]       data_be_i,
`ifdef BRIDGE_ARB_LOCK_EN
  input  logic [N_MASTER-1:0]                      data_lock_i,
`endif
  output logic [N_MASTER-1:0]                      data_gnt_o,
  output logic                                     data_req_o,
  output logic [ADDR_WIDTH-1:0]                    data_add_o,
  output logic                                     data_wen_o,
  output logic [DATA_WIDTH-1:0]                    data_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                  data_be_o,
  output logic [N_MASTER-1:0]                      data_ID_o,
  input  logic                                     data_gnt_i,
  input  logic                                     data_r_valid_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
  output logic                                     err_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [N_MASTER-1:0] req_eff;
  logic [N_MASTER-1:0] sel_onehot;
  logic [IDX_W-1:0]    sel;
  logic                found;
  logic                stall;
  logic                req_c;
  logic                accept;

`ifdef BRIDGE_ARB_LOCK_EN
  logic             lock_q, lock_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;

  // While locked, only the lock owner is visible to the arbiter.
  always_comb begin
    req_eff = data_req_i;
    if (lock_q) req_eff = data_req_i & (N_MASTER'(1) << lock_id_q);
  end
`else
  always_comb req_eff = data_req_i;
`endif

  // Round-robin scan starting at rr_q, wrapping at N_MASTER.
  always_comb begin
    int unsigned idx;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= N_MASTER) idx = idx - N_MASTER;
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
  end

  // Outputs are forced low while reset is asserted.
  assign stall      = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign req_c      = rst_n && found && !stall;
  assign accept     = req_c && data_gnt_i;
  assign sel_onehot = N_MASTER'(1) << sel;

  always_comb begin
    data_req_o   = req_c;
    data_ID_o    = '0;
    data_gnt_o   = '0;
    data_add_o   = '0;
    data_wen_o   = 1'b0;
    data_wdata_o = '0;
    data_be_o    = '0;
    if (req_c) begin
      data_ID_o    = sel_onehot;
      data_add_o   = data_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
      data_wen_o   = data_wen_i[sel];
      data_wdata_o = data_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
      data_be_o    = data_be_i[sel*BE_WIDTH +: BE_WIDTH];
    end
    if (accept) data_gnt_o = sel_onehot;
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  // Pointer, outstanding counter and sticky underflow error.
  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (accept) rr_d = (sel == IDX_W'(N_MASTER - 1)) ? '0 : sel + IDX_W'(1);
    if (accept && !data_r_valid_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (data_r_valid_i && !accept) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else             err_d = 1'b1;
    end
  end

`ifdef BRIDGE_ARB_LOCK_EN
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    if (lock_q && !data_req_i[lock_id_q]) lock_d = 1'b0;
    if (accept) begin
      lock_d    = data_lock_i[sel];
      lock_id_d = sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: tb/tb_xbar_bridge_req_arbiter.sv
// Directed table-driven bench for xbar_bridge_req_arbiter (default params: 20 masters, MAX_OUTSTANDING=4).
module tb_xbar_bridge_req_arbiter;

  localparam int unsigned NM = 20;

  typedef struct {
    logic [NM-1:0] req;
    logic          gnt;
    logic          rv;
    logic [NM-1:0] lock;
    logic [NM-1:0] exp_gnt;
    logic          exp_req;
    logic [NM-1:0] exp_id;
    logic [2:0]    exp_cnt;
    logic          exp_err;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NM-1:0]      data_req_i = '0;
  logic [NM*32-1:0]   data_add_i;
  logic [NM-1:0]      data_wen_i;
  logic [NM*32-1:0]   data_wdata_i;
  logic [NM*4-1:0]    data_be_i;
  logic [NM-1:0]      data_lock = '0;
  logic [NM-1:0]      data_gnt_o;
  logic               data_req_o;
  logic [31:0]        data_add_o;
  logic               data_wen_o;
  logic [31:0]        data_wdata_o;
  logic [3:0]         data_be_o;
  logic [NM-1:0]      data_ID_o;
  logic               data_gnt_i = 1'b0;
  logic               data_r_valid_i = 1'b0;
  logic [2:0]         outstanding_o;
  logic               err_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];
  vec_t lvecs[$];

  always #5 clk = ~clk;

  xbar_bridge_req_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .data_req_i(data_req_i), .data_add_i(data_add_i), .data_wen_i(data_wen_i),
    .data_wdata_i(data_wdata_i), .data_be_i(data_be_i),
`ifdef BRIDGE_ARB_LOCK_EN
    .data_lock_i(data_lock),
`endif
    .data_gnt_o(data_gnt_o), .data_req_o(data_req_o), .data_add_o(data_add_o),
    .data_wen_o(data_wen_o), .data_wdata_o(data_wdata_o), .data_be_o(data_be_o),
    .data_ID_o(data_ID_o), .data_gnt_i(data_gnt_i), .data_r_valid_i(data_r_valid_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  // Distinct per-master payloads so the mux selection is observable.
  function automatic logic [31:0] add_of(int k);
    return 32'hA000_0000 | 32'(k);
  endfunction
  function automatic logic [31:0] wdata_of(int k);
    return 32'h5A00_0000 | (32'(k) << 8);
  endfunction
  function automatic logic [3:0] be_of(int k);
    return 4'(k * 3 + 1);
  endfunction

  initial begin
    for (int k = 0; k < int'(NM); k++) begin
      data_add_i[k*32 +: 32]   = add_of(k);
      data_wdata_i[k*32 +: 32] = wdata_of(k);
      data_be_i[k*4 +: 4]      = be_of(k);
      data_wen_i[k]            = k[0];
    end
  end

  function automatic vec_t v(logic [NM-1:0] req, logic gnt, logic rv, logic [NM-1:0] lock,
                             logic exp_req, logic [NM-1:0] exp_id, logic [2:0] exp_cnt, logic exp_err);
    vec_t r;
    r.req = req; r.gnt = gnt; r.rv = rv; r.lock = lock;
    r.exp_req = exp_req; r.exp_id = exp_id; r.exp_cnt = exp_cnt; r.exp_err = exp_err;
    r.exp_gnt = (gnt && exp_req) ? exp_id : '0;
    return r;
  endfunction

  task automatic chk(string name, int step, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, step, act, exp);
    end
  endtask

  task automatic check_fields(int step, logic [NM-1:0] exp_id);
    logic [31:0] ea = '0, ew = '0;
    logic [3:0]  eb = '0;
    logic        ewen = 1'b0;
    for (int k = 0; k < int'(NM); k++) begin
      if (exp_id[k]) begin
        ea = add_of(k); ew = wdata_of(k); eb = be_of(k); ewen = k[0];
      end
    end
    chk("add", step, 64'(data_add_o), 64'(ea));
    chk("wdata", step, 64'(data_wdata_o), 64'(ew));
    chk("be", step, 64'(data_be_o), 64'(eb));
    chk("wen", step, 64'(data_wen_o), 64'(ewen));
  endtask

  // Drive at posedge+1, compare mid-cycle, then advance one clock.
  task automatic apply(vec_t x, int step);
    data_req_i     = x.req;
    data_gnt_i     = x.gnt;
    data_r_valid_i = x.rv;
    data_lock      = x.lock;
    #4;
    chk("req_o", step, 64'(data_req_o), 64'(x.exp_req));
    chk("id", step, 64'(data_ID_o), 64'(x.exp_id));
    chk("gnt_o", step, 64'(data_gnt_o), 64'(x.exp_gnt));
    chk("cnt", step, 64'(outstanding_o), 64'(x.exp_cnt));
    chk("err", step, 64'(err_o), 64'(x.exp_err));
    check_fields(step, x.exp_id);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    localparam logic [NM-1:0] Z = '0;
    // Round robin over 0,3,5 with one-cycle-late responses
    vecs.push_back(v(20'h00029, 1, 0, Z, 1, 20'h00001, 0, 0));
    vecs.push_back(v(20'h00029, 1, 1, Z, 1, 20'h00008, 1, 0));
    vecs.push_back(v(20'h00029, 1, 1, Z, 1, 20'h00020, 1, 0));
    vecs.push_back(v(20'h00029, 1, 1, Z, 1, 20'h00001, 1, 0));
    vecs.push_back(v(20'h00029, 1, 1, Z, 1, 20'h00008, 1, 0));
    vecs.push_back(v(20'h00029, 1, 1, Z, 1, 20'h00020, 1, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         1, 0));
    vecs.push_back(v(Z,         0, 0, Z, 0, Z,         0, 0));
    // Master 2 waits three cycles for a grant; pointer then moves to 3
    vecs.push_back(v(20'h00004, 0, 0, Z, 1, 20'h00004, 0, 0));
    vecs.push_back(v(20'h00004, 0, 0, Z, 1, 20'h00004, 0, 0));
    vecs.push_back(v(20'h00004, 0, 0, Z, 1, 20'h00004, 0, 0));
    vecs.push_back(v(20'h00004, 1, 0, Z, 1, 20'h00004, 0, 0));
    vecs.push_back(v(20'h0000C, 0, 0, Z, 1, 20'h00008, 1, 0));
    vecs.push_back(v(20'h0000C, 1, 0, Z, 1, 20'h00008, 1, 0));
    // Accept and response together at cnt=2
    vecs.push_back(v(20'h0000C, 1, 1, Z, 1, 20'h00004, 2, 0));
    vecs.push_back(v(Z,         0, 0, Z, 0, Z,         2, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         2, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         1, 0));
    // Fill to MAX_OUTSTANDING, stall, no same-cycle bypass
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 0, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 1, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 2, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 3, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 0, Z,         4, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 0, Z,         4, 0));
    vecs.push_back(v(20'h00001, 1, 1, Z, 0, Z,         4, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 3, 0));
    vecs.push_back(v(20'h00001, 1, 0, Z, 0, Z,         4, 0));
    // Drain, then a response with nothing outstanding
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         4, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         3, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         2, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         1, 0));
    vecs.push_back(v(Z,         0, 1, Z, 0, Z,         0, 0));
    vecs.push_back(v(Z,         0, 0, Z, 0, Z,         0, 1));
    vecs.push_back(v(20'h00001, 1, 0, Z, 1, 20'h00001, 0, 1));
    vecs.push_back(v(Z,         0, 0, Z, 0, Z,         1, 1));

    // Lock: master 1 holds the port for three accepts, then master 4 wins
    lvecs.push_back(v(20'h00012, 1, 0, 20'h00002, 1, 20'h00002, 0, 0));
    lvecs.push_back(v(20'h00012, 1, 1, 20'h00002, 1, 20'h00002, 1, 0));
    lvecs.push_back(v(20'h00012, 1, 1, 20'h00002, 1, 20'h00002, 1, 0));
    lvecs.push_back(v(20'h00012, 1, 1, Z,         1, 20'h00002, 1, 0));
    lvecs.push_back(v(20'h00012, 1, 1, Z,         1, 20'h00010, 1, 0));

    // Outputs stay low during reset even with requests present
    data_req_i = 20'h00029;
    data_gnt_i = 1'b1;
    #3;
    chk("rst_req_o", -1, 64'(data_req_o), 64'(0));
    chk("rst_gnt_o", -1, 64'(data_gnt_o), 64'(0));
    chk("rst_id", -1, 64'(data_ID_o), 64'(0));
    do_reset();

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Reset asserted mid-burst drops outstanding and error state
    data_req_i = 20'h00029;
    data_gnt_i = 1'b1;
    data_r_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req_o", 100, 64'(data_req_o), 64'(0));
    chk("mid_rst_gnt_o", 100, 64'(data_gnt_o), 64'(0));
    chk("mid_rst_id", 100, 64'(data_ID_o), 64'(0));
    chk("mid_rst_add", 100, 64'(data_add_o), 64'(0));
    chk("mid_rst_cnt", 100, 64'(outstanding_o), 64'(0));
    chk("mid_rst_err", 100, 64'(err_o), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    data_gnt_i = 1'b0;
    #3;
    chk("post_rst_id", 101, 64'(data_ID_o), 64'(20'h00001));
    chk("post_rst_gnt_o", 101, 64'(data_gnt_o), 64'(0));
    @(posedge clk);
    #1;
    data_req_i = '0;
    data_r_valid_i = 1'b1;
    @(posedge clk);
    #1;
    data_r_valid_i = 1'b0;
    #2;
    chk("late_rsp_err", 102, 64'(err_o), 64'(1));
    chk("late_rsp_cnt", 102, 64'(outstanding_o), 64'(0));

`ifdef BRIDGE_ARB_LOCK_EN
    do_reset();
    for (int i = 0; i < lvecs.size(); i++) apply(lvecs[i], 200 + i);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
